// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative multiply/divide unit for the MIPS core.
// Owns HI/LO. Multiply is shift-add, retiring MUL_STEP multiplier bits per
// cycle. Divide is restoring, producing one quotient bit per cycle.
// Both operate on operand magnitudes. The sign is applied in a final FIX cycle.
module mips_cpu_muldiv_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MUL_N = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_lo_q, neg_lo_d;     // product / quotient negative
    logic                 neg_hi_q, neg_hi_d;     // remainder negative
    logic                 dz_q, dz_d;             // pending divide-by-zero
    logic [WIDTH-1:0]     a_raw_q, a_raw_d;       // raw dividend for the b==0 result
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_by_zero_q, div_by_zero_d;

    // Operand preparation at start: magnitudes and sign flags.
    logic                 is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & a[WIDTH-1];
    assign b_neg     = is_signed & b[WIDTH-1];
    assign a_mag     = a_neg ? -a : a;
    assign b_mag     = b_neg ? -b : b;

    // One multiply step: conditionally add shifted multiplicand per multiplier bit.
    logic [2*WIDTH-1:0]   mul_chain [MUL_STEP+1];

    assign mul_chain[0] = acc_q;
    generate
        for (genvar gi = 0; gi < MUL_STEP; gi++) begin : g_mul_step
            assign mul_chain[gi+1] = mul_chain[gi] + (mplier_q[gi] ? (mcand_q << gi) : '0);
        end
    endgenerate

    // One restoring divide step. The top bit of the difference acts as the
    // borrow, because the partial remainder always stays below the divisor.
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic                 div_fits;

    assign div_shift = {rem_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, divisor_q};
    assign div_fits  = ~div_diff[WIDTH];

    // Signed results assembled in the FIX cycle.
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     quo_res, rem_res;

    assign prod_res = neg_lo_q ? -acc_q : acc_q;
    assign quo_res  = neg_lo_q ? -quo_q : quo_q;
    assign rem_res  = neg_hi_q ? -rem_q : rem_q;

    // Next-state and datapath update. With clk_enable low, everything holds.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        is_div_d      = is_div_q;
        neg_lo_d      = neg_lo_q;
        neg_hi_d      = neg_hi_q;
        dz_d          = dz_q;
        a_raw_d       = a_raw_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        acc_d         = acc_q;
        divisor_d     = divisor_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = done_q;
        div_by_zero_d = div_by_zero_q;

        if (clk_enable) begin
            done_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mthi) hi_d = mt_data;
                    if (mtlo) lo_d = mt_data;
                    if (start) begin
                        state_d   = S_RUN;
                        is_div_d  = op[1];
                        count_d   = op[1] ? CW'(WIDTH) : CW'(MUL_N);
                        neg_lo_d  = a_neg ^ b_neg;
                        neg_hi_d  = a_neg;
                        dz_d      = op[1] & (b == '0);
                        a_raw_d   = a;
                        mcand_d   = {{WIDTH{1'b0}}, a_mag};
                        mplier_d  = b_mag;
                        acc_d     = '0;
                        divisor_d = b_mag;
                        rem_d     = '0;
                        quo_d     = a_mag;
                    end
                end
                S_RUN: begin
                    if (is_div_q) begin
                        rem_d = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_fits};
                    end else begin
                        acc_d    = mul_chain[MUL_STEP];
                        mcand_d  = mcand_q << MUL_STEP;
                        mplier_d = mplier_q >> MUL_STEP;
                    end
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) state_d = S_FIX;
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_d = prod_res[2*WIDTH-1:WIDTH];
                        lo_d = prod_res[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end
                    div_by_zero_d = is_div_q & dz_q;
                    done_d        = 1'b1;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State register with immediate reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            is_div_q      <= 1'b0;
            neg_lo_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            dz_q          <= 1'b0;
            a_raw_q       <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
            acc_q         <= '0;
            divisor_q     <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            is_div_q      <= is_div_d;
            neg_lo_q      <= neg_lo_d;
            neg_hi_q      <= neg_hi_d;
            dz_q          <= dz_d;
            a_raw_q       <= a_raw_d;
            mcand_q       <= mcand_d;
            mplier_q      <= mplier_d;
            acc_q         <= acc_d;
            divisor_q     <= divisor_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// Bench for mips_cpu_muldiv_iter: directed and random MULT/MULTU/DIV/DIVU
// against an arithmetic reference model, plus handshake, freeze and reset cases.
// A second instance with MUL_STEP=4 runs alongside to check the short multiply.
module tb_mips_cpu_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset, clk_enable, start, start4, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] a, b, mt_data;
    logic        busy, done, dz;
    logic [31:0] hi, lo;
    logic        busy4, done4, dz4;
    logic [31:0] hi4, lo4;

    int n_checks = 0;
    int n_fail   = 0;

    mips_cpu_muldiv_iter #(.WIDTH(32), .MUL_STEP(1)) u_dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .busy(busy), .done(done), .div_by_zero(dz), .hi(hi), .lo(lo)
    );

    mips_cpu_muldiv_iter #(.WIDTH(32), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start4),
        .op(op), .a(a), .b(b), .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .busy(busy4), .done(done4), .div_by_zero(dz4), .hi(hi4), .lo(lo4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %0s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sp;
        logic [63:0] up;
        int          sx, sy, q, r;
        case (o)
            2'b00: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                return {1'b0, 64'(sp)};
            end
            2'b01: begin
                up = {32'd0, x} * {32'd0, y};
                return {1'b0, up};
            end
            2'b10: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                sx = int'(x);
                sy = int'(y);
                q  = sx / sy;
                r  = sx % sy;
                return {1'b0, 32'(r), 32'(q)};
            end
            default: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    // Issue one operation and follow both instances until done (bounded).
    // poke_at: edge after which start+mthi are asserted for one edge mid-run.
    // pause_at/pause_len: clk_enable low for pause_len edges after edge pause_at.
    // with_mt: mthi issued on the same edge as start.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int poke_at, input int pause_at, input int pause_len, input bit with_mt);
        logic [64:0] exp_r, got1, got4;
        logic [31:0] mtv, base_hi, base_lo;
        int          edges, e1, e4, lat1, lat4;
        bit          bad_busy, bad_hold;
        exp_r = model(o, av, bv);
        mtv   = $urandom;
        op = o; a = av; b = bv; start = 1'b1; start4 = 1'b1;
        if (with_mt) begin
            mthi = 1'b1; mt_data = mtv;
        end
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0; mthi = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        check_val("done_clear", 64'(done), 64'd0);
        if (with_mt) check_val("mt_with_start", 64'(hi), 64'(mtv));
        base_hi = hi; base_lo = lo;
        edges = 0; e1 = 0; e4 = 0; bad_busy = 1'b0; bad_hold = 1'b0;
        got1 = '0; got4 = '0;
        while ((e1 == 0 || e4 == 0) && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (e1 == 0) begin
                if (done) begin
                    e1 = edges; got1 = {dz, hi, lo};
                end else begin
                    if (!busy) bad_busy = 1'b1;
                    if (hi !== base_hi || lo !== base_lo) bad_hold = 1'b1;
                end
            end
            if (e4 == 0 && done4) begin
                e4 = edges; got4 = {dz4, hi4, lo4};
            end
            if (edges == poke_at) begin
                start = 1'b1; mthi = 1'b1; mt_data = $urandom; op = 2'($urandom); a = $urandom;
            end else begin
                start = 1'b0; mthi = 1'b0;
            end
            if (pause_at > 0 && edges == pause_at) clk_enable = 1'b0;
            if (pause_at > 0 && edges == pause_at + pause_len) clk_enable = 1'b1;
        end
        start = 1'b0; mthi = 1'b0; clk_enable = 1'b1;
        lat1 = 33;
        lat4 = o[1] ? 33 : 9;
        if (pause_at > 0 && pause_at < lat1) lat1 += pause_len;
        if (pause_at > 0 && pause_at < lat4) lat4 += pause_len;
        check_val("busy_during_run", 64'(bad_busy), 64'd0);
        check_val("hilo_hold_in_run", 64'(bad_hold), 64'd0);
        check_val("latency", 64'(e1), 64'(lat1));
        check_val("hi", 64'(got1[63:32]), 64'(exp_r[63:32]));
        check_val("lo", 64'(got1[31:0]), 64'(exp_r[31:0]));
        check_val("div_by_zero", 64'(got1[64]), 64'(exp_r[64]));
        check_val("latency_step4", 64'(e4), 64'(lat4));
        check_val("hilo_step4", got4[63:0], exp_r[63:0]);
        check_val("dz_step4", 64'(got4[64]), 64'(exp_r[64]));
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d lat=%0d lat4=%0d",
                 o, av, bv, got1[63:32], got1[31:0], got1[64], e1, e4);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;
        reset = 1'b1; clk_enable = 1'b1; start = 1'b0; start4 = 1'b0;
        mthi = 1'b0; mtlo = 1'b0; op = 2'b00; a = '0; b = '0; mt_data = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_dz", 64'(dz), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        $display("reset state: busy=%0d done=%0d hi=%h lo=%h", busy, done, hi, lo);

        // MTHI / MTLO in IDLE
        mthi = 1'b1; mt_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b1; mt_data = 32'h1357_9BDF;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check_val("mthi", 64'(hi), 64'h0000_0000_CAFE_F00D);
        check_val("mtlo", 64'(lo), 64'h0000_0000_1357_9BDF);
        $display("mt writes: hi=%h lo=%h", hi, lo);

        // Directed arithmetic cases
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0, 0, 1'b0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0, 1'b0);
        run_op(2'b11, 32'h0000_0007, 32'h0000_0002, 0, 0, 0, 1'b0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
        run_op(2'b11, 32'h0000_0005, 32'h0000_0000, 0, 0, 0, 1'b0);
        run_op(2'b10, 32'hFFFF_FF00, 32'h0000_0000, 0, 0, 0, 1'b0);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0, 0, 1'b0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0, 0, 1'b0);

        // Handshake cases: mid-run start+mthi ignored, freeze, mt with start
        run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 5, 0, 0, 1'b0);
        run_op(2'b01, 32'hDEAD_BEEF, 32'h0000_1001, 0, 4, 5, 1'b0);
        run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFF3, 0, 20, 5, 1'b0);
        run_op(2'b10, 32'hFFFF_8000, 32'h0000_0123, 0, 0, 0, 1'b1);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin
                ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
            end else if (sel == 2) begin
                ra = ra & 32'h0000_00FF; rb = rb & 32'h0000_000F;
            end else if (sel == 3) begin
                rb = rb | 32'h8000_0000;
            end
            run_op(ro, ra, rb, 0, 0, 0, 1'b0);
        end

        // Asynchronous reset in the middle of a divide
        op = 2'b10; a = 32'h0BAD_CAFE; b = 32'h0000_0013; start = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start4 = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_val("async_rst_busy", 64'(busy), 64'd0);
        check_val("async_rst_busy4", 64'(busy4), 64'd0);
        check_val("async_rst_hi", 64'(hi), 64'd0);
        check_val("async_rst_lo", 64'(lo), 64'd0);
        $display("async reset: busy=%0d hi=%h lo=%h", busy, hi, lo);
        @(negedge clk);
        reset = 1'b0;
        mtlo = 1'b1; mt_data = 32'h0000_1234;
        @(posedge clk); #1;
        mtlo = 1'b0;
        check_val("post_rst_mtlo", 64'(lo), 64'h0000_0000_0000_1234);
        check_val("post_rst_hi", 64'(hi), 64'd0);
        $display("mtlo after reset: lo=%h hi=%h", lo, hi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
